// File: rtl/inst_fetch_responder.sv
// Fetch responder: reads PC (and PC+4 when allowed) over a single-word req/addr_ok/data_ok bus.
// Ok pulses 3 cycles after accept for single and 5 for dual at zero bus wait; bus stalls simply hold state.
module inst_fetch_responder #(
  parameter int LINE_BYTES = 32,
  parameter int DUAL_FETCH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sram_inst_ena,
  input  logic        sram_inst_uncached,
  input  logic [31:0] sram_inst_vaddr,
  input  logic [31:0] sram_inst_psyaddr,
  input  logic        inst_flush,
  output logic [31:0] sram_inst_rdata_1,
  output logic [31:0] sram_inst_rdata_2,
  output logic        sram_inst_ok_1,
  output logic        sram_inst_ok_2,
  output logic        inst_busy,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_addr_ok,
  input  logic        ibus_data_ok,
  input  logic [31:0] ibus_rdata
);

  localparam int OFFW = $clog2(LINE_BYTES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ1  = 3'd1,
    WAIT1 = 3'd2,
    REQ2  = 3'd3,
    WAIT2 = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_addr;
  logic [31:0] r_vaddr;
  logic        r_dual;
  logic        r_cancel;
  logic [31:0] r_rdata_1;
  logic [31:0] r_rdata_2;

  logic        w_accept;
  logic        w_cancel_nxt;
  logic        w_cap_1;
  logic        w_cap_2;
  logic        w_req;
  logic [31:0] w_req_addr;
  logic        w_ok_1;
  logic        w_ok_2;
  logic        w_drop;
  logic        w_line_last;
  logic        w_dual_nxt;
  logic [31:0] w_addr_nxt;
  logic        w_unused;

  assign w_addr_nxt  = {sram_inst_psyaddr[31:2], 2'b00};
  // The second word must stay inside the same line, so the last word of a line fetches alone.
  assign w_line_last = &sram_inst_psyaddr[OFFW-1:2];
  assign w_dual_nxt  = (DUAL_FETCH != 0) && !sram_inst_uncached && !w_line_last;
  assign w_drop      = r_cancel | inst_flush;
  assign w_unused    = ^{r_vaddr, sram_inst_psyaddr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_vaddr   <= '0;
      r_dual    <= 1'b0;
      r_cancel  <= 1'b0;
      r_rdata_1 <= '0;
      r_rdata_2 <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cancel <= w_cancel_nxt;
      if (w_accept) begin
        r_addr  <= w_addr_nxt;
        r_vaddr <= sram_inst_vaddr;
        r_dual  <= w_dual_nxt;
      end
      if (w_cap_1) r_rdata_1 <= ibus_rdata;
      if (w_cap_2) r_rdata_2 <= ibus_rdata;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cancel_nxt = r_cancel;
    w_accept     = 1'b0;
    w_cap_1      = 1'b0;
    w_cap_2      = 1'b0;
    w_req        = 1'b0;
    w_req_addr   = r_addr;
    w_ok_1       = 1'b0;
    w_ok_2       = 1'b0;
    case (r_state)
      IDLE: begin
        w_cancel_nxt = 1'b0;
        if (sram_inst_ena && !inst_flush) begin
          w_accept    = 1'b1;
          w_state_nxt = REQ1;
        end
      end
      // A flushed request still has to be taken by the bus; its data is dropped later.
      REQ1: begin
        w_req = 1'b1;
        if (inst_flush) w_cancel_nxt = 1'b1;
        if (ibus_addr_ok) w_state_nxt = WAIT1;
      end
      WAIT1: begin
        if (inst_flush) w_cancel_nxt = 1'b1;
        if (ibus_data_ok) begin
          if (w_drop) begin
            w_cancel_nxt = 1'b0;
            w_state_nxt  = IDLE;
          end else begin
            w_cap_1     = 1'b1;
            w_state_nxt = r_dual ? REQ2 : RESP;
          end
        end
      end
      REQ2: begin
        w_req      = 1'b1;
        w_req_addr = r_addr + 32'd4;
        if (inst_flush) w_cancel_nxt = 1'b1;
        if (ibus_addr_ok) w_state_nxt = WAIT2;
      end
      WAIT2: begin
        if (inst_flush) w_cancel_nxt = 1'b1;
        if (ibus_data_ok) begin
          if (w_drop) begin
            w_cancel_nxt = 1'b0;
            w_state_nxt  = IDLE;
          end else begin
            w_cap_2     = 1'b1;
            w_state_nxt = RESP;
          end
        end
      end
      RESP: begin
        w_ok_1      = !inst_flush;
        w_ok_2      = r_dual && !inst_flush;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign sram_inst_rdata_1 = r_rdata_1;
  assign sram_inst_rdata_2 = r_rdata_2;
  assign sram_inst_ok_1    = w_ok_1;
  assign sram_inst_ok_2    = w_ok_2;
  assign inst_busy         = (r_state != IDLE);
  assign ibus_req          = w_req;
  assign ibus_addr         = w_req_addr;

endmodule
